// File: rtl/hack_memory_map.sv
// Hack computer data memory: 16K RAM, 8K screen and a keyboard register on one
// CPU port, plus a registered screen read port and a valid/ready keyboard capture path.
module hack_memory_map #(
  parameter int unsigned RAM_WORDS    = 16384,
  parameter int unsigned SCREEN_WORDS = 8192,
  parameter int unsigned KBD_ADDR     = 24576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [14:0] address,
  output logic [15:0] out,
  input  logic [15:0] key_code,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        scan_req,
  input  logic [12:0] scan_addr,
  output logic [15:0] scan_data,
  output logic        scan_valid
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned SCR_AW = $clog2(SCREEN_WORDS);

  typedef enum logic {
    READY = 1'b0,
    HOLD  = 1'b1
  } kbd_state_t;

  logic [15:0]       ram    [RAM_WORDS];
  logic [15:0]       screen [SCREEN_WORDS];
  logic [15:0]       kbd_reg;
  kbd_state_t        state;

  logic [31:0]       addr_w;
  logic              ram_sel;
  logic              scr_sel;
  logic              kbd_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;
  logic              capture;

  // Address decode; anything outside the three regions is unmapped
  assign addr_w  = 32'(address);
  assign ram_sel = addr_w < RAM_WORDS;
  assign scr_sel = (addr_w >= RAM_WORDS) && (addr_w < RAM_WORDS + SCREEN_WORDS);
  assign kbd_sel = addr_w == KBD_ADDR;
  assign ram_idx = RAM_AW'(addr_w);
  assign scr_idx = SCR_AW'(addr_w - RAM_WORDS);

  always_comb begin
    out = 16'h0000;
    if (ram_sel)      out = ram[ram_idx];
    else if (scr_sel) out = screen[scr_idx];
    else if (kbd_sel) out = kbd_reg;
  end

  // Memory arrays have no reset; keyboard and unmapped writes fall through
  always_ff @(posedge clk) begin
    if (load && ram_sel) ram[ram_idx]    <= in;
    if (load && scr_sel) screen[scr_idx] <= in;
  end

  // key_ready follows the state but is held low for as long as reset is high
  assign key_ready = (state == READY) && !reset;
  assign capture   = key_valid && key_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= READY;
      kbd_reg <= 16'h0000;
    end else begin
      case (state)
        READY: begin
          if (capture) begin
            kbd_reg <= key_code;
            state   <= HOLD;
          end
        end
        HOLD:    state <= READY;
        default: state <= READY;
      endcase
    end
  end

  // Scanner reads the pre-edge screen contents, so a same-edge CPU write is not seen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_valid <= 1'b0;
      scan_data  <= 16'h0000;
    end else begin
      scan_valid <= scan_req;
      if (scan_req) scan_data <= screen[SCR_AW'(scan_addr)];
    end
  end

endmodule
